player_ctl_1: RTL

Movement controller for player 1: samples left/right buttons, advances horizontal position and walk-animation state once per video frame, and drives `xpos_player1` / `state` into `draw_player_1`. Sits between the board button inputs and the level-1 draw chain. All outputs change only at the start of vertical blanking, so the drawer never sees a mid-frame position or pose change.

---
 rtl/state_pkg.sv | 23 ++
 rtl/btn_sync.sv | 25 ++
 rtl/player_ctl_1.sv | 113 +++++++++++
 3 files changed

// File: rtl/state_pkg.sv
// Shared player types and sprite geometry for the level-1 controller and drawer.
// Pose enum, sprite width and default walk step live here so both sides agree.
package state_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RIGHT1,
    RIGHT2,
    LEFT1,
    LEFT2
  } State;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_RIGHT,
    DIR_LEFT
  } dir_e;

  localparam int SCREEN_W     = 1024;
  localparam int PLAYER_W     = 40;
  localparam int STEP_DEFAULT = 4;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing one raw asynchronous button into the clk domain.
// Output follows the input after two clk edges.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
    end
  end

  assign btn_o = sync_q;

endmodule

// File: rtl/player_ctl_1.sv
// Player-1 movement: one position/pose update per frame, on the vblnk rising edge.
// Tick one cycle after the edge, outputs updated the cycle after that, all registered.
module player_ctl_1
  import state_pkg::*;
#(
  parameter int X_START     = 100,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - PLAYER_W,
  parameter int STEP        = STEP_DEFAULT,
  parameter int ANIM_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        vblnk,
  output logic [11:0] xpos_player1,
  output State        state,
  output logic        frame_tick
);

  localparam int CW = $clog2(ANIM_FRAMES + 1);

  logic          l_s;
  logic          r_s;
  logic          vblnk_q;
  logic          armed_q;
  logic          frame_tick_q;
  logic [11:0]   xpos_q;
  logic [11:0]   xpos_d;
  logic [12:0]   sum_right;
  logic [CW-1:0] anim_cnt_q;
  State          state_q;
  dir_e          dir;

  btn_sync u_sync_left  (.clk(clk), .rst(rst), .btn_i(btn_left),  .btn_o(l_s));
  btn_sync u_sync_right (.clk(clk), .rst(rst), .btn_i(btn_right), .btn_o(r_s));

  always_comb begin
    dir = DIR_NONE;
    if (r_s && !l_s) dir = DIR_RIGHT;
    else if (l_s && !r_s) dir = DIR_LEFT;
  end

  // 13-bit sum so the right clamp cannot be fooled by a 12-bit wrap.
  always_comb begin
    sum_right = {1'b0, xpos_q} + 13'(STEP);
    xpos_d    = xpos_q;
    if (frame_tick_q) begin
      if (dir == DIR_RIGHT) begin
        xpos_d = (sum_right > 13'(X_MAX)) ? 12'(X_MAX) : sum_right[11:0];
      end else if (dir == DIR_LEFT) begin
        xpos_d = (xpos_q < 12'(X_MIN + STEP)) ? 12'(X_MIN) : xpos_q - 12'(STEP);
      end
    end
  end

  // armed_q blocks a tick from a vblnk that was already high when reset released.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q      <= 1'b0;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      xpos_q       <= 12'(X_START);
      state_q      <= IDLE;
      anim_cnt_q   <= '0;
    end else begin
      vblnk_q      <= vblnk;
      if (!vblnk) armed_q <= 1'b1;
      frame_tick_q <= vblnk && !vblnk_q && armed_q;
      xpos_q       <= xpos_d;
      if (frame_tick_q) begin
        case (dir)
          DIR_RIGHT: begin
            if (state_q == RIGHT1 || state_q == RIGHT2) begin
              if (anim_cnt_q == CW'(ANIM_FRAMES - 1)) begin
                state_q    <= (state_q == RIGHT1) ? RIGHT2 : RIGHT1;
                anim_cnt_q <= '0;
              end else begin
                anim_cnt_q <= anim_cnt_q + CW'(1);
              end
            end else begin
              state_q    <= RIGHT1;
              anim_cnt_q <= '0;
            end
          end
          DIR_LEFT: begin
            if (state_q == LEFT1 || state_q == LEFT2) begin
              if (anim_cnt_q == CW'(ANIM_FRAMES - 1)) begin
                state_q    <= (state_q == LEFT1) ? LEFT2 : LEFT1;
                anim_cnt_q <= '0;
              end else begin
                anim_cnt_q <= anim_cnt_q + CW'(1);
              end
            end else begin
              state_q    <= LEFT1;
              anim_cnt_q <= '0;
            end
          end
          default: begin
            state_q    <= IDLE;
            anim_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign xpos_player1 = xpos_q;
  assign state        = state_q;
  assign frame_tick   = frame_tick_q;

endmodule
